// File: rtl/plru_repl_unit_if.sv
// ============================================================================
// Module      : plru_repl_unit_if
// Description : Request/response bus between a cache controller and the
//               tree-PLRU replacement unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface plru_repl_unit_if #(
    parameter int IDX_W = 7,
    parameter int WAY_W = 2
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [IDX_W-1:0] req_set;
    logic [WAY_W-1:0] req_way;
    logic             rsp_valid;
    logic [WAY_W-1:0] rsp_way;

    modport master (
        output req_valid, req_op, req_set, req_way,
        input  req_ready, rsp_valid, rsp_way
    );

    modport slave (
        input  req_valid, req_op, req_set, req_way,
        output req_ready, rsp_valid, rsp_way
    );
endinterface

`default_nettype wire

// File: rtl/plru_repl_unit.sv
// ============================================================================
// Module      : plru_repl_unit
// Description : Tree pseudo-LRU replacement state for a set-associative cache
//               with TOUCH/ALLOC/PEEK/INVAL requests and 1-cycle responses.
//               Optional macro PLRU_STATS_EN adds TOUCH/ALLOC counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module plru_repl_unit #(
    parameter int SETS = 128,
    parameter int WAYS = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         flush,
    plru_repl_unit_if.slave   bus,
`ifdef PLRU_STATS_EN
    output logic [15:0]       stat_touch,
    output logic [15:0]       stat_alloc,
`endif
    output logic              busy
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int PLRU_W = WAYS - 1;

    localparam logic [1:0] OP_TOUCH = 2'b00;
    localparam logic [1:0] OP_ALLOC = 2'b01;
    localparam logic [1:0] OP_PEEK  = 2'b10;
    localparam logic [1:0] OP_INVAL = 2'b11;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic               w_req_ready;

    logic [PLRU_W-1:0]  r_plru [SETS];
    logic [PLRU_W-1:0]  w_rd_bits;
    logic [PLRU_W-1:0]  w_upd_bits;
    logic [PLRU_W-1:0]  w_wr_data;
    logic [IDX_W-1:0]   w_wr_idx;
    logic               w_wr_en;
    logic               w_accept;
    logic [WAY_W-1:0]   w_victim;
    logic [WAY_W-1:0]   w_rsp_way_nxt;

    logic               r_rsp_valid;
    logic [WAY_W-1:0]   r_rsp_way;

    // Walk from the root following each node bit; the bits taken form the way.
    function automatic logic [WAY_W-1:0] f_victim(input logic [PLRU_W-1:0] bits);
        logic [WAY_W-1:0]  way;
        logic [PLRU_W-1:0] sh;
        int                node;
        way  = '0;
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            sh   = bits >> node;
            way  = (way << 1) | WAY_W'(sh[0]);
            node = 2 * node + 1 + (sh[0] ? 1 : 0);
        end
        return way;
    endfunction

    // Every node on the way's path is pointed at the opposite subtree.
    function automatic logic [PLRU_W-1:0] f_touch(input logic [PLRU_W-1:0] bits,
                                                  input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] res;
        logic [PLRU_W-1:0] one;
        logic [WAY_W-1:0]  sh;
        int                node;
        res  = bits;
        one  = PLRU_W'(1);
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            sh = way >> (WAY_W - 1 - lvl);
            if (sh[0]) begin
                res = res & ~(one << node);
            end else begin
                res = res | (one << node);
            end
            node = 2 * node + 1 + (sh[0] ? 1 : 0);
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_req_ready = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_INIT: begin
                busy = 1'b1;
                if (flush) begin
                    w_ptr_nxt = '0;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                    if (r_ptr == IDX_W'(SETS - 1)) begin
                        w_state_nxt = ST_READY;
                    end
                end
            end
            ST_READY: begin
                w_req_ready = !flush;
                if (flush) begin
                    w_state_nxt = ST_INIT;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign bus.req_ready = w_req_ready;

    // Reset overrides a request presented in the same cycle.
    assign w_accept  = bus.req_valid & w_req_ready & !reset;
    assign w_rd_bits = r_plru[bus.req_set];
    assign w_victim  = f_victim(w_rd_bits);

    always_comb begin
        w_upd_bits    = w_rd_bits;
        w_rsp_way_nxt = '0;
        case (bus.req_op)
            OP_TOUCH: begin
                w_upd_bits    = f_touch(w_rd_bits, bus.req_way);
                w_rsp_way_nxt = bus.req_way;
            end
            OP_ALLOC: begin
                w_upd_bits    = f_touch(w_rd_bits, w_victim);
                w_rsp_way_nxt = w_victim;
            end
            OP_PEEK: begin
                w_upd_bits    = w_rd_bits;
                w_rsp_way_nxt = w_victim;
            end
            OP_INVAL: begin
                w_upd_bits    = '0;
                w_rsp_way_nxt = '0;
            end
            default: begin
                w_upd_bits    = w_rd_bits;
                w_rsp_way_nxt = '0;
            end
        endcase
    end

    assign w_wr_en   = (r_state == ST_INIT) | (w_accept & (bus.req_op != OP_PEEK));
    assign w_wr_idx  = (r_state == ST_INIT) ? r_ptr : bus.req_set;
    assign w_wr_data = (r_state == ST_INIT) ? '0 : w_upd_bits;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_plru[w_wr_idx] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_way   <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_way <= w_rsp_way_nxt;
            end
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_way   = r_rsp_way;

`ifdef PLRU_STATS_EN
    logic [15:0] r_stat_touch;
    logic [15:0] r_stat_alloc;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_stat_touch <= '0;
            r_stat_alloc <= '0;
        end else begin
            if (w_accept && (bus.req_op == OP_TOUCH) && (r_stat_touch != 16'hFFFF)) begin
                r_stat_touch <= r_stat_touch + 16'd1;
            end
            if (w_accept && (bus.req_op == OP_ALLOC) && (r_stat_alloc != 16'hFFFF)) begin
                r_stat_alloc <= r_stat_alloc + 16'd1;
            end
        end
    end

    assign stat_touch = r_stat_touch;
    assign stat_alloc = r_stat_alloc;
`endif

endmodule

`default_nettype wire
